// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Registered program counter for the single-cycle MIPS datapath. Computes the
//   sequential, branch, jump and jump-register targets internally and adds
//   stall, halt/resume and exception redirection with EPC capture.
//
// Ports
//   clk, reset      rising-edge clock; asynchronous active-high reset
//   stall           hold pc this cycle
//   halt, resume    enter / leave the HALTED state
//   exception       load EXC_VECTOR, capture current pc into epc
//   pc_src          00 seq, 01 jump, 10 jump-register, 11 branch
//   branch_taken    qualifies pc_src = 11
//   imm16           signed word offset for branches
//   target26        jump target field
//   reg_a           rs value for jump-register
//   pc              registered current pc
//   pc_plus4        pc + 4, combinational (also the jal link value)
//   redirect        high for the cycle after any non-sequential pc load
//   halted          high while in HALTED
//   epc             pc of the last accepted excepting instruction
module pc_sequencer #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0080)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic             exception,
  input  logic [1:0]       pc_src,
  input  logic             branch_taken,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target26,
  input  logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             redirect,
  output logic             halted,
  output logic [WIDTH-1:0] epc
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pc_n, epc_n;
  logic             redir_n;
  logic [WIDTH-1:0] br_tgt, jmp_tgt, jr_tgt;

  assign pc_plus4 = pc + WIDTH'(4);
  assign br_tgt   = pc_plus4 + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
  assign jmp_tgt  = {pc_plus4[WIDTH-1:28], target26, 2'b00};
  // Misaligned jr targets are silently aligned; no fault path exists.
  assign jr_tgt   = reg_a & ~WIDTH'(3);

  // halted is a pure decode of the state flop, so it lines up with pc.
  assign halted = (state == HALTED);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    epc_n   = epc;
    redir_n = 1'b0;
    unique case (state)
      RUN: begin
        if (exception) begin
          pc_n    = EXC_VECTOR;
          epc_n   = pc;
          redir_n = 1'b1;
        end else if (halt) begin
          state_n = HALTED;
        end else if (!stall) begin
          unique case (pc_src)
            2'b01: begin pc_n = jmp_tgt; redir_n = 1'b1; end
            2'b10: begin pc_n = jr_tgt;  redir_n = 1'b1; end
            2'b11: begin
              // Taken branch flags redirect even if target equals pc+4.
              if (branch_taken) begin
                pc_n    = br_tgt;
                redir_n = 1'b1;
              end else begin
                pc_n = pc_plus4;
              end
            end
            default: pc_n = pc_plus4;
          endcase
        end
      end
      HALTED: begin
        // Leaving HALTED only flips state; pc advances on the following edge.
        if (resume && !halt) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      epc      <= '0;
      redirect <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      epc      <= epc_n;
      redirect <= redir_n;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: each step pushes its expected outcome onto a
// scoreboard queue, then pops and compares it after the clock edge.
module tb_pc_sequencer;

  logic        clk, reset, stall, halt, resume, exception, branch_taken;
  logic [1:0]  pc_src;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] reg_a;
  logic [31:0] pc, pc_plus4, epc, pc2, pc_plus4_2, epc2;
  logic        redirect, halted, redirect2, halted2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        redir;
    logic        halted;
    logic [31:0] epc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_epc;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
    .exception(exception), .pc_src(pc_src), .branch_taken(branch_taken),
    .imm16(imm16), .target26(target26), .reg_a(reg_a),
    .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect), .halted(halted), .epc(epc)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
    .exception(exception), .pc_src(pc_src), .branch_taken(branch_taken),
    .imm16(imm16), .target26(target26), .reg_a(reg_a),
    .pc(pc2), .pc_plus4(pc_plus4_2), .redirect(redirect2), .halted(halted2), .epc(epc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; halt = 0; resume = 0; exception = 0;
    pc_src = 2'b00; branch_taken = 0; imm16 = '0; target26 = '0; reg_a = '0;
  endtask

  // Push expectation, clock once, pop and compare.
  task automatic step(input string tag, input logic [31:0] e_pc,
                      input logic e_rd, input logic e_h);
    exp_t e;
    exp_q.push_back('{pc: e_pc, redir: e_rd, halted: e_h, epc: exp_epc});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "/queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "/pc"},       pc,                 e.pc);
      chk({tag, "/pc_plus4"}, pc_plus4,           e.pc + 32'd4);
      chk({tag, "/redirect"}, {31'd0, redirect},  {31'd0, e.redir});
      chk({tag, "/halted"},   {31'd0, halted},    {31'd0, e.halted});
      chk({tag, "/epc"},      epc,                e.epc);
    end
  endtask

  // Force the pc to a known value with a jump-register.
  task automatic load_pc(input logic [31:0] v);
    idle(); pc_src = 2'b10; reg_a = v;
    step("load", v, 1'b1, 1'b0);
  endtask

  initial begin
    idle();
    exp_epc = 32'd0;
    reset = 1'b1;
    #12;
    chk("rst/pc", pc, 32'd0);
    chk("rst/pc_plus4", pc_plus4, 32'd4);
    chk("rst/epc", epc, 32'd0);
    chk("rst/redirect", {31'd0, redirect}, 32'd0);
    chk("rst/halted", {31'd0, halted}, 32'd0);
    chk("rst2/pc", pc2, 32'hFFFF_FFFC);
    reset = 1'b0;

    // Sequential run from reset; second instance wraps to 0.
    step("seq1", 32'd4, 1'b0, 1'b0);
    chk("wrap2/pc", pc2, 32'd0);
    chk("wrap2/redirect", {31'd0, redirect2}, 32'd0);
    chk("wrap2/halted", {31'd0, halted2}, 32'd0);
    chk("wrap2/epc", epc2, 32'd0);
    step("seq2", 32'd8, 1'b0, 1'b0);
    step("seq3", 32'd12, 1'b0, 1'b0);

    // Asynchronous reset between edges.
    reset = 1'b1;
    #1;
    chk("async_rst/pc", pc, 32'd0);
    chk("async_rst/redirect", {31'd0, redirect}, 32'd0);
    #1;
    reset = 1'b0;
    step("post_rst", 32'd4, 1'b0, 1'b0);

    // Branch taken backwards, then not taken.
    load_pc(32'h100);
    idle(); pc_src = 2'b11; branch_taken = 1; imm16 = 16'hFFFE;
    step("br_taken", 32'hFC, 1'b1, 1'b0);
    load_pc(32'h100);
    idle(); pc_src = 2'b11; branch_taken = 0; imm16 = 16'hFFFE;
    step("br_not", 32'h104, 1'b0, 1'b0);
    idle(); pc_src = 2'b11; branch_taken = 1; imm16 = 16'h0000;
    step("br_eq_seq", 32'h108, 1'b1, 1'b0);
    idle();
    step("redir_drop", 32'h10C, 1'b0, 1'b0);

    // Jump and jump-register.
    load_pc(32'h1000_0000);
    idle(); pc_src = 2'b01; target26 = 26'h0000040;
    step("jump", 32'h1000_0100, 1'b1, 1'b0);
    idle(); pc_src = 2'b10; reg_a = 32'h0000_2003;
    step("jr", 32'h0000_2000, 1'b1, 1'b0);

    // Exception beats stall; then stall alone holds.
    load_pc(32'h40);
    idle(); stall = 1; exception = 1; pc_src = 2'b01;
    exp_epc = 32'h40;
    step("exc", 32'h80, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; pc_src = 2'b01;
      step("stall", 32'h80, 1'b0, 1'b0);
    end

    // Halt, ignored inputs while halted, halt+resume, resume.
    load_pc(32'h20);
    idle(); halt = 1;
    step("halt", 32'h20, 1'b0, 1'b1);
    idle(); exception = 1; pc_src = 2'b01; target26 = 26'h3FF;
    step("halt_ign", 32'h20, 1'b0, 1'b1);
    idle(); halt = 1; resume = 1;
    step("halt_res", 32'h20, 1'b0, 1'b1);
    idle(); resume = 1;
    step("resume", 32'h20, 1'b0, 1'b0);
    idle();
    step("after_res", 32'h24, 1'b0, 1'b0);

    // Wrap-around on the default instance.
    load_pc(32'hFFFF_FFFC);
    idle();
    step("wrap", 32'h0, 1'b0, 1'b0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the single-cycle MIPS datapath. It replaces the hard-wired next-PC multiplexing with one registered block. The block holds the PC and computes PC+4, branch, jump and jump-register targets internally. It adds stall, halt/resume and exception redirection with EPC capture. It sits between the control unit and instruction memory, and `pc_plus4` feeds the link-register write path for `jal`.

## Interface
Parameters:
- WIDTH, 32, PC/data width; must be ≥ 32
- RESET_PC, 0, PC value loaded on reset
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception

Ports:
- clk  in  1  rising-edge clock, sole clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC this cycle
- halt  in  1  request entry to HALTED
- resume  in  1  request exit from HALTED
- exception  in  1  redirect to EXC_VECTOR, capture EPC
- pc_src  in  2  00 sequential, 01 jump, 10 jump-register, 11 branch
- branch_taken  in  1  qualifies pc_src=11
- imm16  in  16  branch offset in words, signed
- target26  in  26  jump target field
- reg_a  in  WIDTH  jump-register source (rs value)
- pc  out  WIDTH  registered current PC
- pc_plus4  out  WIDTH  combinational pc+4
- redirect  out  1  registered; high for the cycle after any non-sequential PC load
- halted  out  1  registered; high while in HALTED
- epc  out  WIDTH  registered PC of the excepting instruction

## Operation
- State machine has two states, RUN and HALTED. Reset enters RUN.
- Target arithmetic, all modulo 2^WIDTH:
  - seq = pc_plus4 = pc + 4
  - br = pc_plus4 + (sign_extend(imm16) << 2)
  - jmp = {pc_plus4[WIDTH-1:28], target26, 2'b00}
  - jr = {reg_a[WIDTH-1:2], 2'b00}; the low bits are forced to zero and no fault is raised
- Next-PC priority in RUN, highest first:
  1. exception: pc←EXC_VECTOR, epc←pc, redirect←1
  2. halt: state←HALTED, pc held, redirect←0
  3. stall: pc held, redirect←0
  4. pc_src=01: pc←jmp, redirect←1
  5. pc_src=10: pc←jr, redirect←1
  6. pc_src=11 with branch_taken=1: pc←br, redirect←1
  7. pc_src=11 with branch_taken=0, or pc_src=00: pc←seq, redirect←0
- In HALTED:
  - pc and epc are held and redirect=0.
  - exception, stall and pc_src are ignored.
  - resume=1 with halt=0 sets state←RUN; pc is unchanged.
  - resume=1 with halt=1 keeps the block in HALTED.
- A branch target equal to seq still asserts redirect, because the load is non-sequential by decode.
- epc changes only on an accepted exception.

## Timing
- Reset, asynchronous and immediate: pc=RESET_PC, epc=0, redirect=0, halted=0, state=RUN.
- Reset deasserted mid-operation: the first update occurs at the next rising clk edge.
- Latency:
  - All state updates take effect at the rising clk edge.
  - pc reflects a selection one cycle after the inputs are sampled.
  - pc_plus4 follows pc combinationally, with zero cycles of latency.
- redirect and halted are registered and coincide with the new pc value.
- Exiting HALTED costs one cycle: the first RUN-state PC update happens the edge after resume is sampled.
- Wrap-around: pc = 2^WIDTH−4 advances sequentially to 0 with no flag.

## Test plan
- Reset, then 3 edges with pc_src=00 → pc = 0, 4, 8, 12. Assert reset mid-cycle → pc=0 immediately, without waiting for a clk edge.
- Branch taken, pc=0x100, imm16=0xFFFE → pc=0xFC, redirect=1 for one cycle. Branch not taken → pc=0x104, redirect=0.
- Jump with pc=0x1000_0000, target26=0x0000040 → pc=0x1000_0100. Jump-register with reg_a=0x0000_2003 → pc=0x0000_2000.
- Stall plus exception in the same cycle at pc=0x40 → pc=0x80, epc=0x40, redirect=1. Stall alone → pc held for the duration of stall.
- halt at pc=0x20 → halted=1 and pc=0x20 held. While halted, exception and pc_src=01 are ignored. halt and resume together keep the block halted. resume alone → halted=0, and the next edge gives pc=0x24.
- RESET_PC=32'hFFFF_FFFC with a sequential step → pc=0, no other output change.
